// File: rtl/tcam_scan.sv
// Sequential-scan TCAM: DEPTH entries searched 2^GROUP_LOG at a time, reporting first match and match count.
// Optional TCAM_MASK_EN adds a per-entry care mask (ternary compare); default build is exact binary match.
module tcam_scan #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 6,
  parameter int GROUP_LOG  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  write_enable,
  input  logic                  erase,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
`ifdef TCAM_MASK_EN
  input  logic [DATA_WIDTH-1:0] write_mask,
`endif
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  busy,
  output logic                  done,
  output logic                  match,
  output logic [ADDR_WIDTH-1:0] match_addr,
  output logic                  multi_match,
  output logic [ADDR_WIDTH:0]   match_count
);

  // state | meaning
  // IDLE  | waiting for start; writes/erases accepted
  // SCAN  | comparing one group of entries per cycle
  // DONE  | one-cycle result pulse; writes and start ignored

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int GSIZE  = 1 << GROUP_LOG;
  localparam int GROUPS = DEPTH / GSIZE;
  localparam int CNT_W  = (ADDR_WIDTH > GROUP_LOG) ? (ADDR_WIDTH - GROUP_LOG) : 1;
  localparam int IW     = (GROUP_LOG > 0) ? GROUP_LOG : 1;
  localparam int PW     = GROUP_LOG + 1;
  localparam int CW     = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(GROUPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] entry_data [DEPTH];
`ifdef TCAM_MASK_EN
  logic [DATA_WIDTH-1:0] entry_mask [DEPTH];
`endif
  logic [DEPTH-1:0]      valid;

  logic [DATA_WIDTH-1:0] key;
  logic [CNT_W-1:0]      grp;
  logic                  found;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [CW-1:0]         count_r;

  logic                  wr_ok;
  logic [ADDR_WIDTH-1:0] grp_base;
  logic [GSIZE-1:0]      grp_hits;
  logic [PW-1:0]         grp_pop;
  logic [IW-1:0]         first_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SCAN;
      SCAN:    if (grp == LAST_GRP) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The table is only mutable while idle, so a scan always sees a stable snapshot.
  assign wr_ok = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (wr_ok) begin
      if (write_enable) begin
        valid[write_addr] <= 1'b1;
      end else if (erase) begin
        valid[write_addr] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && write_enable) begin
      entry_data[write_addr] <= write_data;
`ifdef TCAM_MASK_EN
      entry_mask[write_addr] <= write_mask;
`endif
    end
  end

  assign grp_base = ADDR_WIDTH'(grp) << GROUP_LOG;

  always_comb begin
    grp_hits = '0;
    for (int i = 0; i < GSIZE; i++) begin
      logic [ADDR_WIDTH-1:0] idx;
      logic [DATA_WIDTH-1:0] care;
      idx  = grp_base | ADDR_WIDTH'(i);
`ifdef TCAM_MASK_EN
      care = entry_mask[idx];
`else
      care = '1;
`endif
      grp_hits[i] = valid[idx] && (((entry_data[idx] ^ key) & care) == '0);
    end
  end

  // Walk downward so the last hit seen is the lowest index in the group.
  always_comb begin
    grp_pop   = '0;
    first_idx = '0;
    for (int i = GSIZE - 1; i >= 0; i--) begin
      if (grp_hits[i]) begin
        grp_pop   = grp_pop + PW'(1);
        first_idx = IW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key     <= '0;
      grp     <= '0;
      found   <= 1'b0;
      addr_r  <= '0;
      count_r <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            key     <= din;
            grp     <= '0;
            found   <= 1'b0;
            addr_r  <= '0;
            count_r <= '0;
          end
        end
        SCAN: begin
          count_r <= count_r + CW'(grp_pop);
          if (!found && (grp_pop != '0)) begin
            found  <= 1'b1;
            addr_r <= grp_base | ADDR_WIDTH'(first_idx);
          end
          grp <= (grp == LAST_GRP) ? '0 : grp + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state == SCAN);
  assign done        = (state == DONE);
  assign match       = found;
  assign match_addr  = addr_r;
  assign match_count = count_r;
  assign multi_match = (count_r >= CW'(2));

endmodule

// File: tb/tb_tcam_scan.sv
// Self-checking bench for tcam_scan: table-driven write/erase/search vectors plus hand-built corner sequences.
// Search expectations go into a scoreboard queue at start and are checked when done pulses.
module tb_tcam_scan;

  localparam int DW  = 128;
  localparam int AW  = 6;
  localparam int LAT = 17;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          write_enable;
  logic          erase;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
`ifdef TCAM_MASK_EN
  logic [DW-1:0] write_mask;
`endif
  logic          start;
  logic [DW-1:0] din;
  logic          busy;
  logic          done;
  logic          match;
  logic [AW-1:0] match_addr;
  logic          multi_match;
  logic [AW:0]   match_count;

  tcam_scan dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_enable (write_enable),
    .erase        (erase),
    .write_addr   (write_addr),
    .write_data   (write_data),
`ifdef TCAM_MASK_EN
    .write_mask   (write_mask),
`endif
    .start        (start),
    .din          (din),
    .busy         (busy),
    .done         (done),
    .match        (match),
    .match_addr   (match_addr),
    .multi_match  (multi_match),
    .match_count  (match_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          m;
    logic [AW-1:0] a;
    logic [AW:0]   c;
    int            t0;
  } exp_t;

  typedef struct {
    int            kind;   // 0 write, 1 erase, 2 search
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          exp_m;
    logic [AW-1:0] exp_a;
    logic [AW:0]   exp_c;
  } vec_t;

  exp_t sb[$];
  exp_t e_mon;
  vec_t tbl[15];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   done_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  always @(posedge clk) begin
    #1;
    if (done) begin
      done_seen++;
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, expected no done", cyc);
      end else begin
        e_mon = sb.pop_front();
        check("match", DW'(match), DW'(e_mon.m));
        check("match_addr", DW'(match_addr), DW'(e_mon.a));
        check("match_count", DW'(match_count), DW'(e_mon.c));
        check("multi_match", DW'(multi_match), DW'(e_mon.c >= 2));
        check("busy_in_done", DW'(busy), DW'(0));
        check("latency", DW'(cyc - e_mon.t0), DW'(LAT));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_idle();
    write_enable = 1'b1; write_addr = a; write_data = d;
`ifdef TCAM_MASK_EN
    write_mask = '1;
`endif
    @(negedge clk);
    write_enable = 1'b0;
  endtask

  task automatic do_erase(input logic [AW-1:0] a);
    wait_idle();
    erase = 1'b1; write_addr = a;
    @(negedge clk);
    erase = 1'b0;
  endtask

  task automatic start_search(input logic [DW-1:0] k, input logic m, input logic [AW-1:0] a,
                              input logic [AW:0] c);
    wait_idle();
    start = 1'b1; din = k;
    sb.push_back('{m: m, a: a, c: c, t0: cyc});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    @(posedge clk); #1;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", n);
    end
  endtask

  task automatic search(input logic [DW-1:0] k, input logic m, input logic [AW-1:0] a,
                        input logic [AW:0] c);
    start_search(k, m, a, c);
    wait_done();
    repeat (2) @(posedge clk);
    #1;
    check("hold_addr", DW'(match_addr), DW'(a));
    check("hold_count", DW'(match_count), DW'(c));
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; write_enable = 1'b0; erase = 1'b0; write_addr = '0; write_data = '0;
`ifdef TCAM_MASK_EN
    write_mask = '1;
`endif
    start = 1'b0; din = '0;

    tbl[0]  = '{0, 6'd0,  128'h0,    1'b0, 6'd0, 7'd0};
    tbl[1]  = '{0, 6'd1,  128'h0,    1'b0, 6'd0, 7'd0};
    tbl[2]  = '{2, 6'd0,  128'h0,    1'b1, 6'd0, 7'd2};
    tbl[3]  = '{2, 6'd0,  128'h1111, 1'b0, 6'd0, 7'd0};
    tbl[4]  = '{1, 6'd0,  128'h0,    1'b0, 6'd0, 7'd0};
    tbl[5]  = '{2, 6'd0,  128'h0,    1'b1, 6'd1, 7'd1};
    tbl[6]  = '{0, 6'd5,  128'hAA55, 1'b0, 6'd0, 7'd0};
    tbl[7]  = '{0, 6'd9,  128'hAA55, 1'b0, 6'd0, 7'd0};
    tbl[8]  = '{0, 6'd40, 128'hAA55, 1'b0, 6'd0, 7'd0};
    tbl[9]  = '{2, 6'd0,  128'hAA55, 1'b1, 6'd5, 7'd3};
    tbl[10] = '{0, 6'd9,  128'h1234, 1'b0, 6'd0, 7'd0};
    tbl[11] = '{2, 6'd0,  128'hAA55, 1'b1, 6'd5, 7'd2};
    tbl[12] = '{2, 6'd0,  128'h1234, 1'b1, 6'd9, 7'd1};
    tbl[13] = '{0, 6'd2,  128'h0,    1'b0, 6'd0, 7'd0};
    tbl[14] = '{2, 6'd0,  128'h0,    1'b1, 6'd1, 7'd2};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    check("rst_match", DW'(match), DW'(0));
    check("rst_addr", DW'(match_addr), DW'(0));
    check("rst_multi", DW'(multi_match), DW'(0));
    check("rst_count", DW'(match_count), DW'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      case (tbl[i].kind)
        0: do_write(tbl[i].addr, tbl[i].data);
        1: do_erase(tbl[i].addr);
        default: search(tbl[i].data, tbl[i].exp_m, tbl[i].exp_a, tbl[i].exp_c);
      endcase
    end
    // valid now: 1=0, 2=0, 5=AA55, 9=1234, 40=AA55

    // start pulsed mid-scan is ignored: one done, first key's results
    d0 = done_seen;
    start_search(128'h0, 1'b1, 6'd1, 7'd2);
    repeat (4) @(negedge clk);
    start = 1'b1; din = 128'h1234;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (30) @(posedge clk);
    #1;
    check("single_done", DW'(done_seen - d0), DW'(1));

    // write during SCAN is dropped
    start_search(128'h0, 1'b1, 6'd1, 7'd2);
    repeat (3) @(negedge clk);
    write_enable = 1'b1; write_addr = 6'd63; write_data = 128'hABCD;
    @(negedge clk);
    write_enable = 1'b0;
    wait_done();
    search(128'hABCD, 1'b0, 6'd0, 7'd0);

    // write during DONE is dropped
    start_search(128'h0, 1'b1, 6'd1, 7'd2);
    wait_done();
    @(negedge clk);
    write_enable = 1'b1; write_addr = 6'd62; write_data = 128'hABCD;
    @(negedge clk);
    write_enable = 1'b0;
    do_write(6'd63, 128'hABCD);
    search(128'hABCD, 1'b1, 6'd63, 7'd1);

    // write and start in the same idle cycle: search sees the new entry
    wait_idle();
    write_enable = 1'b1; write_addr = 6'd20; write_data = 128'h7777;
    start = 1'b1; din = 128'h7777;
    sb.push_back('{m: 1'b1, a: 6'd20, c: 7'd1, t0: cyc});
    @(negedge clk);
    write_enable = 1'b0; start = 1'b0;
    wait_done();

    // reset mid-scan aborts without done
    wait_idle();
    d0 = done_seen;
    start = 1'b1; din = '0;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", DW'(busy), DW'(0));
    check("abort_done", DW'(done), DW'(0));
    check("abort_match", DW'(match), DW'(0));
    check("abort_count", DW'(match_count), DW'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("abort_no_done", DW'(done_seen - d0), DW'(0));
    search(128'h0, 1'b0, 6'd0, 7'd0);

`ifdef TCAM_MASK_EN
    wait_idle();
    write_enable = 1'b1; write_addr = 6'd7; write_data = 128'hFF00; write_mask = 128'hFF00;
    @(negedge clk);
    write_enable = 1'b0; write_mask = '1;
    search(128'hFF5A, 1'b1, 6'd7, 7'd1);
    search(128'hFE00, 1'b0, 6'd0, 7'd0);
`else
    do_write(6'd7, 128'hFF00);
    search(128'hFF00, 1'b1, 6'd7, 7'd1);
    search(128'hFF5A, 1'b0, 6'd0, 7'd0);
`endif

    repeat (5) @(posedge clk);
    #1;
    check("scoreboard_drained", DW'(sb.size()), DW'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tcam_scan.md
TCAM_SCAN -- requirements
Module: tcam_scan

Interface
REQ-001 The block SHALL have a single clock domain, with reset synchronous and active-low.
REQ-002 Parameter DATA_WIDTH SHALL default to 128 and sets the key/entry width in bits.
REQ-003 Parameter ADDR_WIDTH SHALL default to 6 and sets DEPTH = 2^ADDR_WIDTH entries.
REQ-004 Parameter GROUP_LOG SHALL default to 2; 2^GROUP_LOG entries are compared per cycle, and GROUP_LOG <= ADDR_WIDTH.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 write_enable  input  1  writes the entry at write_addr.
REQ-008 erase  input  1  invalidates the entry at write_addr; ignored when write_enable=1 in the same cycle.
REQ-009 write_addr  input  ADDR_WIDTH  write/erase target.
REQ-010 write_data  input  DATA_WIDTH  entry value.
REQ-011 write_mask  input  DATA_WIDTH  per-bit care mask, 1 = compare (present only with TCAM_MASK_EN).
REQ-012 start  input  1  one-cycle search request.
REQ-013 din  input  DATA_WIDTH  search key, sampled when start is accepted.
REQ-014 busy  output  1  search in progress.
REQ-015 done  output  1  one-cycle pulse; results valid.
REQ-016 match  output  1  at least one valid entry matched.
REQ-017 match_addr  output  ADDR_WIDTH  lowest matching address.
REQ-018 multi_match  output  1  two or more entries matched.
REQ-019 match_count  output  ADDR_WIDTH+1  number of matching entries, 0..DEPTH.

Function
REQ-020 The FSM SHALL have states IDLE, SCAN and DONE: IDLE->SCAN on start, SCAN->DONE after the last group, DONE->IDLE unconditionally.
REQ-021 A start in IDLE SHALL latch din into an internal key register, clear the group counter and accumulators, and set busy=1 from the next cycle.
REQ-022 SCAN SHALL compare group g (entries g*2^GROUP_LOG .. +2^GROUP_LOG-1) in cycle g, for DEPTH/2^GROUP_LOG cycles, with the group counter wrapping to 0 on exit.
REQ-023 An entry SHALL match when valid=1 and ((entry XOR key) AND mask) == 0; the mask is all-ones without TCAM_MASK_EN.
REQ-024 The first (lowest-address) match SHALL be captured into match_addr, and later matches SHALL NOT overwrite it.
REQ-025 match_count SHALL accumulate the per-group popcount of matches; multi_match SHALL equal (match_count >= 2).
REQ-026 done SHALL pulse in DONE with busy=0, giving latency from the start edge to done high of DEPTH/2^GROUP_LOG + 1 cycles.
REQ-027 match, match_addr, multi_match and match_count SHALL hold from done until the next accepted start; with no match, match=0, match_addr=0 and match_count=0.
REQ-028 start while busy=1 or in DONE SHALL be ignored.
REQ-029 Writes and erases SHALL commit at the clock edge only when busy=0 and the FSM is not in DONE; writes in SCAN/DONE SHALL be dropped, with no side effects.
REQ-030 When write and start occur in the same IDLE cycle, the write SHALL commit and the search SHALL see the new entry.
REQ-031 A write SHALL set valid=1, and an erase SHALL clear valid, leaving data unchanged.

Reset
REQ-032 rst_n=0 SHALL force state IDLE, clear all valid bits, zero the key register, counter and accumulators, and drive busy=0, done=0, match=0, match_addr=0, multi_match=0, match_count=0.
REQ-033 Reset during SCAN SHALL abort the search with no done pulse; entry data contents after reset are don't-care.

Configuration
REQ-034 With TCAM_MASK_EN defined, write_mask is a port and a per-entry DATA_WIDTH mask register is stored with each write, giving ternary compare.
REQ-035 Without TCAM_MASK_EN, write_mask and the mask storage SHALL be absent and the compare SHALL be exact binary.

Verification
REQ-036 Write 128'h0 to address 0 and 128'h0 to address 1, then start with din=0 -> done at cycle 17; match=1, match_addr=0, multi_match=1, match_count=2.
REQ-037 With the same contents, start with din=128'h1111 -> done at cycle 17; match=0, match_addr=0, match_count=0.
REQ-038 Erase address 0, then search 0 -> match_addr=1, match_count=1, multi_match=0; a start pulsed during SCAN is ignored, with only one done seen.
REQ-039 Write address 63=128'hABCD during SCAN, then search 128'hABCD -> no match, because the write was dropped; rewrite in IDLE and search -> match_addr=63.
REQ-040 Assert rst_n=0 at SCAN cycle 5 -> no done, busy=0 next cycle, and a search of 0 after reset gives match=0.
REQ-041 With TCAM_MASK_EN: write address 7 data 128'hFF00 mask 128'hFF00, search 128'hFF5A -> match=1, match_addr=7; search 128'hFE00 -> match=0.
